// File: rtl/task2_fill_screen.sv
// Screen-fill engine: sweeps the 160x120 framebuffer column by column, one pixel per clock,
// colouring each pixel by x mod 8, then parks in DONE. Includes the 160x120 VGA adapter it feeds.

module vga_adapter (
    input  logic       resetn,
    input  logic       clock,
    input  logic [2:0] colour,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK
);
    localparam int FB_DEPTH = 160 * 120;

    logic [2:0]  r_mem [0:FB_DEPTH-1];
    logic        r_pix_en;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [2:0]  r_rd_data;
    logic        r_hs;
    logic        r_vs;
    logic        w_visible;
    logic [14:0] w_wr_addr;
    logic [14:0] w_rd_addr;

    // Each framebuffer pixel covers a 4x4 block of the 640x480 raster.
    assign w_visible = (r_hcnt < 10'd640) && (r_vcnt < 10'd480);
    assign w_wr_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
    assign w_rd_addr = 15'({r_vcnt[8:2], 7'b0}) + 15'({r_vcnt[8:2], 5'b0}) + 15'(r_hcnt[9:2]);

    // NOTE: the framebuffer has no reset; clearing 19200 entries at once would force it out of block RAM.
    always_ff @(posedge clock) begin
        if (plot && (x < 8'd160) && (y < 7'd120))
            r_mem[w_wr_addr] <= colour;
        r_rd_data <= w_visible ? r_mem[w_rd_addr] : 3'd0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pix_en <= 1'b0;
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
        end else begin
            r_pix_en <= ~r_pix_en;
            r_hs     <= !((r_hcnt >= 10'd656) && (r_hcnt < 10'd752));
            r_vs     <= !((r_vcnt >= 10'd490) && (r_vcnt < 10'd492));
            if (r_pix_en) begin
                if (r_hcnt == 10'd799) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == 10'd524) ? 10'd0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
            end
        end
    end

    assign VGA_R   = {8{r_rd_data[2]}};
    assign VGA_G   = {8{r_rd_data[1]}};
    assign VGA_B   = {8{r_rd_data[0]}};
    assign VGA_HS  = r_hs;
    assign VGA_VS  = r_vs;
    assign VGA_CLK = r_pix_en;
endmodule

module task2_fill_screen #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOUR,
    output logic       VGA_PLOT
);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    typedef enum logic {S_FILL, S_DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_x;
    logic [7:0] w_x_nxt;
    logic [6:0] r_y;
    logic [6:0] w_y_nxt;
    logic       w_unused_inputs;

    assign w_unused_inputs = ^{SW, KEY[2:0]};

    // NOTE: reset is sampled only on the clock edge, so it lives inside the clocked block's if, not its sensitivity list.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY[3]) begin
            r_state <= S_FILL;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        if (r_state == S_FILL) begin
            if (r_y < Y_LAST) begin
                w_y_nxt = r_y + 7'd1;
            end else if (r_x < X_LAST) begin
                w_y_nxt = '0;
                w_x_nxt = r_x + 8'd1;
            end else begin
                w_state_nxt = S_DONE;
            end
        end
    end

    assign VGA_X      = r_x;
    assign VGA_Y      = r_y;
    assign VGA_COLOUR = r_x[2:0];
    assign VGA_PLOT   = (r_state == S_FILL);
    assign LEDR       = {9'b0, (r_state == S_DONE)};
    assign HEX0       = 7'b1111111;
    assign HEX1       = 7'b1111111;
    assign HEX2       = 7'b1111111;
    assign HEX3       = 7'b1111111;
    assign HEX4       = 7'b1111111;
    assign HEX5       = 7'b1111111;

    vga_adapter u_vga (
        .resetn  (KEY[3]),
        .clock   (CLOCK_50),
        .colour  (VGA_COLOUR),
        .x       (VGA_X),
        .y       (VGA_Y),
        .plot    (VGA_PLOT),
        .VGA_R   (VGA_R),
        .VGA_G   (VGA_G),
        .VGA_B   (VGA_B),
        .VGA_HS  (VGA_HS),
        .VGA_VS  (VGA_VS),
        .VGA_CLK (VGA_CLK)
    );
endmodule

// File: tb/tb_task2_fill_screen.sv
// Self-checking bench for task2_fill_screen: checkpoint table, full sweeps, DONE hold,
// mid-fill reset and immunity to SW / KEY[2:0].

module tb_task2_fill_screen;
    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_clk;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    task2_fill_screen dut (
        .CLOCK_50   (clk),
        .KEY        (key),
        .SW         (sw),
        .LEDR       (ledr),
        .HEX0       (hex0),
        .HEX1       (hex1),
        .HEX2       (hex2),
        .HEX3       (hex3),
        .HEX4       (hex4),
        .HEX5       (hex5),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_CLK    (vga_clk),
        .VGA_X      (vga_x),
        .VGA_Y      (vga_y),
        .VGA_COLOUR (vga_colour),
        .VGA_PLOT   (vga_plot)
    );

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       plot;
        logic       done;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the edge, i.e. well before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        key[3] = 1'b0;
        tick();
        key[3] = 1'b1;
        cyc = 0;
    endtask

    task automatic sweep(input string tag, input bit rnd);
        for (int i = 0; i < 160; i++) begin
            for (int j = 0; j < 120; j++) begin
                check($sformatf("%s(%0d,%0d)", tag, i, j),
                      {45'd0, vga_x, vga_y, vga_colour, vga_plot},
                      {45'd0, 8'(i), 7'(j), 3'(i % 8), 1'b1});
                if (rnd) begin
                    sw       = 10'($urandom);
                    key[2:0] = 3'($urandom);
                end
                tick();
            end
        end
        check({tag, "_end_plot"}, {63'd0, vga_plot}, 64'd0);
        check({tag, "_end_done"}, {54'd0, ledr},     64'd1);
    endtask

    initial begin
        logic [18:0] frozen;

        vecs[0] = '{cyc: 0,     x: 8'd0,   y: 7'd0,   c: 3'd0, plot: 1'b1, done: 1'b0};
        vecs[1] = '{cyc: 1,     x: 8'd0,   y: 7'd1,   c: 3'd0, plot: 1'b1, done: 1'b0};
        vecs[2] = '{cyc: 119,   x: 8'd0,   y: 7'd119, c: 3'd0, plot: 1'b1, done: 1'b0};
        vecs[3] = '{cyc: 120,   x: 8'd1,   y: 7'd0,   c: 3'd1, plot: 1'b1, done: 1'b0};
        vecs[4] = '{cyc: 959,   x: 8'd7,   y: 7'd119, c: 3'd7, plot: 1'b1, done: 1'b0};
        vecs[5] = '{cyc: 960,   x: 8'd8,   y: 7'd0,   c: 3'd0, plot: 1'b1, done: 1'b0};
        vecs[6] = '{cyc: 19199, x: 8'd159, y: 7'd119, c: 3'd7, plot: 1'b1, done: 1'b0};
        vecs[7] = '{cyc: 19200, x: 8'd159, y: 7'd119, c: 3'd7, plot: 1'b0, done: 1'b1};

        key = 4'b1111;
        sw  = 10'd0;
        #2;

        // Reset state right after the reset edge
        do_reset();
        check("rst_x",    {56'd0, vga_x},      64'd0);
        check("rst_y",    {57'd0, vga_y},      64'd0);
        check("rst_col",  {61'd0, vga_colour}, 64'd0);
        check("rst_plot", {63'd0, vga_plot},   64'd1);
        check("rst_ledr", {54'd0, ledr},       64'd0);
        check("hex_blank", {22'd0, hex5, hex4, hex3, hex2, hex1, hex0}, {22'd0, {42{1'b1}}});

        // Checkpoint table along one uninterrupted fill
        for (int k = 0; k < 8; k++) begin
            while (cyc < vecs[k].cyc) tick();
            check($sformatf("vec%0d_pix", vecs[k].cyc),
                  {45'd0, vga_x, vga_y, vga_colour, vga_plot},
                  {45'd0, vecs[k].x, vecs[k].y, vecs[k].c, vecs[k].plot});
            check($sformatf("vec%0d_ledr", vecs[k].cyc), {54'd0, ledr}, {54'd0, 9'd0, vecs[k].done});
        end

        // DONE must hold for 100 further cycles
        frozen = {8'd159, 7'd119, 3'd7, 1'b0};
        for (int k = 0; k < 100; k++) begin
            tick();
            check($sformatf("hold%0d", k),
                  {44'd0, ledr[0], vga_x, vga_y, vga_colour, vga_plot},
                  {44'd0, 1'b1, frozen});
        end

        // Reset out of DONE, then a full clean sweep
        do_reset();
        sweep("sweep", 1'b0);

        // Reset mid-fill at pixel (37,55)
        do_reset();
        while (cyc < 37 * 120 + 55) tick();
        check("pre_rst_pix", {49'd0, vga_x, vga_y}, {49'd0, 8'd37, 7'd55});
        do_reset();
        check("mid_rst_pix", {45'd0, vga_x, vga_y, vga_colour, vga_plot}, {45'd0, 8'd0, 7'd0, 3'd0, 1'b1});

        // Resumed fill with SW and KEY[2:0] toggling
        sweep("rsweep", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
